// File: rtl/sha256_sched_pkg.sv
// sha256_sched_pkg
//   Definitions shared by the SHA-256 job scheduler and its arbiter.
//   - sched_state_t     : scheduler state encoding
//   - ADDR_W            : width of one message / output word address
//   - WAIT_BUSY_TIMEOUT : cycles to wait for the core to leave idle before
//                         the start pulse is repeated
package sha256_sched_pkg;

    localparam int ADDR_W            = 16;
    localparam int WAIT_BUSY_TIMEOUT = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ACK       = 3'd4
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. The search for an eligible requester
//   (req high and mask low) starts at ptr and wraps from NUM_REQ-1 to 0.
//   Ports:
//     req       in   NUM_REQ          request vector
//     mask      in   NUM_REQ          requesters excluded from this search
//     ptr       in   $clog2(NUM_REQ)  first index to consider
//     gnt_valid out  1                an eligible requester was found
//     gnt_idx   out  $clog2(NUM_REQ)  index of the winning requester
module rr_arbiter
    import sha256_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         mask,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       gnt_valid,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] elig;
    logic [IDX_W-1:0]   cand_idx;
    int                 cand;

    assign elig = req & ~mask;

    // Scan from the farthest candidate back towards ptr so that the last
    // hit, which overrides earlier ones, is the one nearest to ptr.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (elig[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler
//   Shares one SHA-256 core between NUM_REQ requesters. A requester raises
//   req with its message/output addresses; the scheduler picks one by
//   round-robin, pulses core_start with the latched addresses, waits for
//   the core to go busy and come back idle, and then pulses that
//   requester's ack. If the core does not react to a start within
//   WAIT_BUSY_TIMEOUT cycles the start is repeated.
//   Ports:
//     clk               in   1                 clock (also the core clock)
//     reset             in   1                 async active-high reset
//     req               in   NUM_REQ           level request per requester
//     req_msg_addr      in   NUM_REQ*16        packed message addresses
//     req_out_addr      in   NUM_REQ*16        packed hash output addresses
//     ack               out  NUM_REQ           one-cycle completion pulse
//     busy              out  1                 a job is in progress
//     grant_id          out  $clog2(NUM_REQ)   current / last granted index
//     job_cycles        out  CNT_W             duration of the last job
//     core_start        out  1                 start pulse to the core
//     core_message_addr out  16                message address to the core
//     core_output_addr  out  16                output address to the core
//     core_done         in   1                 core idle (1) / computing (0)
module sha256_job_scheduler
    import sha256_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_msg_addr,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_out_addr,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [CNT_W-1:0]           job_cycles,
    output logic                       core_start,
    output logic [ADDR_W-1:0]          core_message_addr,
    output logic [ADDR_W-1:0]          core_output_addr,
    input  logic                       core_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WB_W  = $clog2(WAIT_BUSY_TIMEOUT);
    localparam logic [WB_W-1:0] WB_LAST = WB_W'(WAIT_BUSY_TIMEOUT - 1);

    sched_state_t       state;
    logic [IDX_W-1:0]   ptr;
    logic [NUM_REQ-1:0] mask;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [WB_W-1:0]    wb_cnt;
    logic               gnt_valid;
    logic [IDX_W-1:0]   gnt_idx;

    // Job cycle counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
        return (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + IDX_W'(1);
    endfunction

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req),
        .mask      (mask),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= ST_IDLE;
            ptr               <= '0;
            mask              <= '0;
            cyc_cnt           <= '0;
            wb_cnt            <= '0;
            ack               <= '0;
            busy              <= 1'b0;
            grant_id          <= '0;
            job_cycles        <= '0;
            core_start        <= 1'b0;
            core_message_addr <= '0;
            core_output_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The mask only covers the first IDLE cycle after an ack.
                    mask <= '0;
                    if (gnt_valid && core_done) begin
                        state             <= ST_ISSUE;
                        grant_id          <= gnt_idx;
                        ptr               <= next_ptr(gnt_idx);
                        core_message_addr <= req_msg_addr[ADDR_W*int'(gnt_idx) +: ADDR_W];
                        core_output_addr  <= req_out_addr[ADDR_W*int'(gnt_idx) +: ADDR_W];
                        core_start        <= 1'b1;
                        busy              <= 1'b1;
                        cyc_cnt           <= '0;
                    end
                end

                ST_ISSUE: begin
                    core_start <= 1'b0;
                    wb_cnt     <= '0;
                    cyc_cnt    <= sat_inc(cyc_cnt);
                    state      <= ST_WAIT_BUSY;
                end

                ST_WAIT_BUSY: begin
                    cyc_cnt <= sat_inc(cyc_cnt);
                    if (!core_done) begin
                        state <= ST_WAIT_DONE;
                    end else if (wb_cnt == WB_LAST) begin
                        // Core never left idle: assume the start was lost.
                        state      <= ST_ISSUE;
                        core_start <= 1'b1;
                        cyc_cnt    <= '0;
                    end else begin
                        wb_cnt <= wb_cnt + WB_W'(1);
                    end
                end

                ST_WAIT_DONE: begin
                    cyc_cnt <= sat_inc(cyc_cnt);
                    if (core_done) begin
                        // job_cycles is the counter value seen in the ACK cycle.
                        state      <= ST_ACK;
                        ack        <= one_hot(grant_id);
                        job_cycles <= sat_inc(cyc_cnt);
                    end
                end

                ST_ACK: begin
                    ack   <= '0;
                    busy  <= 1'b0;
                    mask  <= one_hot(grant_id);
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sha256_job_scheduler.md
SHA256_JOB_SCHEDULER -- requirements
Module: sha256_job_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one SHA-256 core; legal range 2..8.
REQ-002 Parameter CNT_W, default 16: width of the job cycle counter.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock; it is also the core clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req  input  NUM_REQ  level request per requester; the requester holds it until its ack.
REQ-007 req_msg_addr  input  NUM_REQ*16  packed message word addresses; requester i occupies bits [16i+15:16i].
REQ-008 req_out_addr  input  NUM_REQ*16  packed hash output word addresses, using the same packing.
REQ-009 ack  output  NUM_REQ  one-cycle completion pulse per requester.
REQ-010 busy  output  1  high while a job is in progress, in any non-IDLE state.
REQ-011 grant_id  output  $clog2(NUM_REQ)  index of the current or last granted requester.
REQ-012 job_cycles  output  CNT_W  core cycles taken by the last completed job.
REQ-013 core_start  output  1  start pulse to the core.
REQ-014 core_message_addr, core_output_addr  output  16 each  addresses driven to the core.
REQ-015 core_done  input  1  core idle indicator; high while the core is idle, low while it is computing.

Function
REQ-016 The state machine SHALL have five states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ACK.
REQ-017 IDLE: if any unmasked req is high and core_done=1, the block SHALL grant by round-robin, latch that requester's addresses and grant_id, and go to ISSUE; otherwise it stays in IDLE.
REQ-018 Round-robin: search starts at pointer ptr and wraps from NUM_REQ-1 to 0; after a grant to requester g, ptr becomes (g+1) mod NUM_REQ.
REQ-019 ISSUE: core_start=1 for exactly this one cycle, with the core addresses stable; next state is WAIT_BUSY.
REQ-020 WAIT_BUSY: on core_done=0 go to WAIT_DONE.
REQ-021 WAIT_BUSY timeout: if core_done is still 1 after 4 cycles, return to ISSUE and re-pulse core_start; there is no limit on retries.
REQ-022 WAIT_DONE: on core_done=1 go to ACK.
REQ-023 Cycle counter: cleared on entry to ISSUE, incremented every cycle until ACK, and saturating at all-ones.
REQ-024 ACK: ack[grant_id]=1 for one cycle, job_cycles is loaded from the counter, and the next state is IDLE.
REQ-025 All outputs SHALL be registered; core_start goes high in the cycle after the cycle in which req is sampled in IDLE.
REQ-026 The acknowledged requester's req SHALL be masked in the first IDLE cycle after ACK, so it is not re-granted before it can drop req.
REQ-027 If req drops mid-job, the job SHALL still complete and ack still pulses.
REQ-028 Requests arriving during a job SHALL wait until IDLE; latched addresses are unaffected by input changes after the grant.
REQ-029 If core_done=0 while in IDLE, the block SHALL not grant.

Reset
REQ-030 On reset the block SHALL enter IDLE with ptr=0, grant_id=0, ack=0, busy=0, core_start=0, job_cycles=0, core_message_addr=0, core_output_addr=0, and mask cleared.
REQ-031 Reset mid-job SHALL abort the job immediately with no ack; the core is not reset by this block.

Structure
REQ-032 A shared package sha256_sched_pkg SHALL hold the state enum, ADDR_W=16, and WAIT_BUSY_TIMEOUT=4.
REQ-033 One sub-module SHALL be used: rr_arbiter, which is combinational and takes req, mask, and ptr, and returns a grant valid flag and the grant index.

Verification
REQ-034 Single request: req=4'b0001, msg=16'h0000, out=16'h0100, with a core model that drops done 1 cycle after start and raises it 100 cycles later -> one core_start, ack[0] pulse, grant_id=0, job_cycles about 102.
REQ-035 Contention: req=4'b1111 held and re-raised after each ack -> grant order 0,1,2,3,0; exactly one ack per job.
REQ-036 Pointer wrap: ptr=3 and req=4'b1001 -> grant 3 then 0.
REQ-037 Start lost: the core model ignores the first start -> a second core_start pulse 5 cycles after the first, and the job still completes.
REQ-038 Mid-job reset: reset asserted in WAIT_DONE -> all outputs at reset values in the same cycle, and no ack.
REQ-039 Address stability: req_msg_addr changes after the grant -> core_message_addr stays at the latched value until the next grant.
